calc1_port_scheduler: RTL

- Front-end that lets four requesters share one calc1-style arithmetic/shift backend.
- Captures each port's two-cycle command (cmd + operand 1, then operand 2) into a one-deep holding buffer.
- Arbitrates round-robin, dispatches one operation at a time over a valid/ready request channel, and routes the tagged response back to the originating port.
- Sits between the four requester interfaces and the shared ALU, and supervises each backend operation with a timeout.

---
 rtl/calc1_port_scheduler.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/calc1_port_scheduler.sv
// calc1_port_scheduler: captures two-cycle commands from four requesters, dispatches
// them round-robin to one shared calc1 backend and routes tagged responses home.
module calc1_port_scheduler #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        req1_cmd_in,
    input  logic [3:0]        req2_cmd_in,
    input  logic [3:0]        req3_cmd_in,
    input  logic [3:0]        req4_cmd_in,
    input  logic [DATA_W-1:0] req1_data_in,
    input  logic [DATA_W-1:0] req2_data_in,
    input  logic [DATA_W-1:0] req3_data_in,
    input  logic [DATA_W-1:0] req4_data_in,
    output logic [1:0]        out_resp1,
    output logic [1:0]        out_resp2,
    output logic [1:0]        out_resp3,
    output logic [1:0]        out_resp4,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic [DATA_W-1:0] out_data4,
    output logic              alu_req_valid,
    input  logic              alu_req_ready,
    output logic [3:0]        alu_cmd,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [1:0]        alu_tag,
    input  logic              alu_rsp_valid,
    input  logic [1:0]        alu_rsp_tag,
    input  logic [1:0]        alu_rsp_code,
    input  logic [DATA_W-1:0] alu_rsp_data
);
    typedef enum logic [1:0] {P_EMPTY = 2'd0, P_GOT_CMD = 2'd1, P_PENDING = 2'd2} port_st_e;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} fsm_e;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    function automatic logic cmd_supported(input logic [3:0] cmd);
        logic ok;
        case (cmd)
            4'd1, 4'd2, 4'd5, 4'd6: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [3:0]        cmd_in_s  [4];
    logic [DATA_W-1:0] data_in_s [4];

    assign cmd_in_s[0]  = req1_cmd_in;
    assign cmd_in_s[1]  = req2_cmd_in;
    assign cmd_in_s[2]  = req3_cmd_in;
    assign cmd_in_s[3]  = req4_cmd_in;
    assign data_in_s[0] = req1_data_in;
    assign data_in_s[1] = req2_data_in;
    assign data_in_s[2] = req3_data_in;
    assign data_in_s[3] = req4_data_in;

    port_st_e          port_st_q [4];
    port_st_e          port_st_d [4];
    logic [3:0]        buf_cmd_q [4];
    logic [3:0]        buf_cmd_d [4];
    logic [DATA_W-1:0] buf_op1_q [4];
    logic [DATA_W-1:0] buf_op1_d [4];
    logic [DATA_W-1:0] buf_op2_q [4];
    logic [DATA_W-1:0] buf_op2_d [4];
    logic [1:0]        resp_q    [4];
    logic [1:0]        resp_d    [4];
    logic [DATA_W-1:0] data_q    [4];
    logic [DATA_W-1:0] data_d    [4];

    fsm_e              fsm_q, fsm_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        tag_q, tag_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              alu_valid_q, alu_valid_d;
    logic [3:0]        alu_cmd_q, alu_cmd_d;
    logic [DATA_W-1:0] alu_op1_q, alu_op1_d;
    logic [DATA_W-1:0] alu_op2_q, alu_op2_d;
    logic [1:0]        alu_tag_q, alu_tag_d;

    logic [3:0]        elig_s;
    logic              gnt_found_s;
    logic [1:0]        gnt_idx_s;

    // A port completing a valid operand-2 cycle competes alongside PENDING ports,
    // so the request can be on the bus the cycle right after operand 2.
    always_comb begin
        elig_s = 4'd0;
        for (int i = 0; i < 4; i++) begin
            elig_s[i] = (port_st_q[i] == P_PENDING) ||
                        ((port_st_q[i] == P_GOT_CMD) && cmd_supported(buf_cmd_q[i]));
        end
    end

    // Round-robin search starting at the pointer.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] idx_v;
            idx_v = ptr_q + 2'(k);
            if (!gnt_found_s && elig_s[idx_v]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = idx_v;
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // Port capture, dispatch FSM and response routing.
    always_comb begin
        fsm_d       = fsm_q;
        ptr_d       = ptr_q;
        tag_d       = tag_q;
        cnt_d       = cnt_q;
        alu_valid_d = alu_valid_q;
        alu_cmd_d   = alu_cmd_q;
        alu_op1_d   = alu_op1_q;
        alu_op2_d   = alu_op2_q;
        alu_tag_d   = alu_tag_q;
        for (int i = 0; i < 4; i++) begin
            port_st_d[i] = port_st_q[i];
            buf_cmd_d[i] = buf_cmd_q[i];
            buf_op1_d[i] = buf_op1_q[i];
            buf_op2_d[i] = buf_op2_q[i];
            resp_d[i]    = 2'd0;
            data_d[i]    = {DATA_W{1'b0}};
        end

        for (int i = 0; i < 4; i++) begin
            case (port_st_q[i])
                P_EMPTY: begin
                    if (cmd_in_s[i] != 4'd0) begin
                        port_st_d[i] = P_GOT_CMD;
                        buf_cmd_d[i] = cmd_in_s[i];
                        buf_op1_d[i] = data_in_s[i];
                    end else begin
                        port_st_d[i] = P_EMPTY;
                    end
                end
                P_GOT_CMD: begin
                    buf_op2_d[i] = data_in_s[i];
                    if (cmd_supported(buf_cmd_q[i])) begin
                        port_st_d[i] = P_PENDING;
                    end else begin
                        port_st_d[i] = P_EMPTY;
                        resp_d[i]    = 2'd2;
                    end
                end
                P_PENDING: port_st_d[i] = P_PENDING;
                default:   port_st_d[i] = P_EMPTY;
            endcase
        end

        case (fsm_q)
            S_IDLE: begin
                if (gnt_found_s) begin
                    alu_valid_d = 1'b1;
                    alu_cmd_d   = buf_cmd_q[gnt_idx_s];
                    alu_op1_d   = buf_op1_q[gnt_idx_s];
                    alu_op2_d   = (port_st_q[gnt_idx_s] == P_GOT_CMD) ? data_in_s[gnt_idx_s]
                                                                     : buf_op2_q[gnt_idx_s];
                    alu_tag_d   = gnt_idx_s;
                    tag_d       = gnt_idx_s;
                    ptr_d       = gnt_idx_s + 2'd1;
                    fsm_d       = S_ISSUE;
                end else begin
                    fsm_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (alu_req_ready) begin
                    alu_valid_d = 1'b0;
                    cnt_d       = 8'd0;
                    fsm_d       = S_WAIT;
                end else begin
                    fsm_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (alu_rsp_valid && (alu_rsp_tag == tag_q)) begin
                    resp_d[tag_q]    = alu_rsp_code;
                    data_d[tag_q]    = alu_rsp_data;
                    port_st_d[tag_q] = P_EMPTY;
                    fsm_d            = S_IDLE;
                end else if (cnt_q >= TIMEOUT_C) begin
                    resp_d[tag_q]    = 2'd3;
                    port_st_d[tag_q] = P_EMPTY;
                    fsm_d            = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                alu_valid_d = 1'b0;
                fsm_d       = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            fsm_q       <= S_IDLE;
            ptr_q       <= 2'd0;
            tag_q       <= 2'd0;
            cnt_q       <= 8'd0;
            alu_valid_q <= 1'b0;
            alu_cmd_q   <= 4'd0;
            alu_op1_q   <= {DATA_W{1'b0}};
            alu_op2_q   <= {DATA_W{1'b0}};
            alu_tag_q   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                port_st_q[i] <= P_EMPTY;
                buf_cmd_q[i] <= 4'd0;
                buf_op1_q[i] <= {DATA_W{1'b0}};
                buf_op2_q[i] <= {DATA_W{1'b0}};
                resp_q[i]    <= 2'd0;
                data_q[i]    <= {DATA_W{1'b0}};
            end
        end else begin
            fsm_q       <= fsm_d;
            ptr_q       <= ptr_d;
            tag_q       <= tag_d;
            cnt_q       <= cnt_d;
            alu_valid_q <= alu_valid_d;
            alu_cmd_q   <= alu_cmd_d;
            alu_op1_q   <= alu_op1_d;
            alu_op2_q   <= alu_op2_d;
            alu_tag_q   <= alu_tag_d;
            for (int i = 0; i < 4; i++) begin
                port_st_q[i] <= port_st_d[i];
                buf_cmd_q[i] <= buf_cmd_d[i];
                buf_op1_q[i] <= buf_op1_d[i];
                buf_op2_q[i] <= buf_op2_d[i];
                resp_q[i]    <= resp_d[i];
                data_q[i]    <= data_d[i];
            end
        end
    end

    assign alu_req_valid = alu_valid_q;
    assign alu_cmd       = alu_cmd_q;
    assign alu_op1       = alu_op1_q;
    assign alu_op2       = alu_op2_q;
    assign alu_tag       = alu_tag_q;
    assign out_resp1     = resp_q[0];
    assign out_resp2     = resp_q[1];
    assign out_resp3     = resp_q[2];
    assign out_resp4     = resp_q[3];
    assign out_data1     = data_q[0];
    assign out_data2     = data_q[1];
    assign out_data3     = data_q[2];
    assign out_data4     = data_q[3];
endmodule
